// File: rtl/lc3b_mem_responder.sv
// rtl/lc3b_mem_responder.sv - LC-3b memory responder: fixed-latency word RAM answering MEMEN with R.
// Optional MEM_ALIGN_CHECK_EN adds ERR for misaligned word accesses.
module lc3b_mem_responder #(
    parameter int ADDR_W  = 16,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MEMEN,
    input  logic              R_W,
    input  logic              DATASIZE,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [15:0]       WDATA,
    output logic [15:0]       RDATA,
    output logic              R
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic              ERR
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;

    localparam logic [3:0] LAT = 4'(LATENCY);

    state_t              state, state_nx;
    logic [3:0]          cnt, cnt_nx;
    logic                complete;
    logic                misalign;
    logic [ADDR_W-2:0]   idx;
    logic [15:0]         word_rd;
    logic [7:0]          lane_rd;
    logic [15:0]         rd_val;
    logic [15:0]         mem [0:(1<<(ADDR_W-1))-1];

    assign idx     = ADDR[ADDR_W-1:1];
    assign word_rd = mem[idx];
    assign lane_rd = ADDR[0] ? word_rd[15:8] : word_rd[7:0];
    assign rd_val  = DATASIZE ? word_rd : {{8{lane_rd[7]}}, lane_rd};
    assign R       = (state == READY);

`ifdef MEM_ALIGN_CHECK_EN
    logic err_q;
    assign misalign = DATASIZE & ADDR[0];
    assign ERR      = R & err_q;

    always_ff @(posedge clk) begin
        if (!reset)
            err_q <= 1'b0;
        else if (complete)
            err_q <= misalign;
    end
`else
    assign misalign = 1'b0;
`endif

    // complete marks the single edge on which the access happens
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        complete = 1'b0;
        case (state)
            IDLE: begin
                if (MEMEN) begin
                    cnt_nx = 4'd1;
                    if (LAT == 4'd1) begin
                        state_nx = READY;
                        complete = 1'b1;
                    end else begin
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!MEMEN) begin
                    state_nx = IDLE;
                    cnt_nx   = 4'd0;
                end else begin
                    cnt_nx = cnt + 4'd1;
                    if (cnt_nx == LAT) begin
                        state_nx = READY;
                        complete = 1'b1;
                    end
                end
            end
            READY: begin
                if (!MEMEN) begin
                    state_nx = IDLE;
                    cnt_nx   = 4'd0;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            RDATA <= 16'h0000;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (complete && !R_W && !misalign)
                RDATA <= rd_val;
        end
    end

    // Array is never cleared; a reset edge blocks the commit
    always_ff @(posedge clk) begin
        if (reset && complete && R_W && !misalign) begin
            if (DATASIZE)
                mem[idx] <= WDATA;
            else if (ADDR[0])
                mem[idx][15:8] <= WDATA[7:0];
            else
                mem[idx][7:0] <= WDATA[7:0];
        end
    end

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// tb/tb_lc3b_mem_responder.sv - self-checking bench for lc3b_mem_responder (LATENCY 4 and 1 side by side).
module tb_lc3b_mem_responder;

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, MEMEN, R_W, DATASIZE;
    logic [15:0] ADDR, WDATA;
    logic [15:0] rdata4, rdata1;
    logic        r4, r1, err4, err1;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    int          run   [2];
    int          lat   [2] = '{4, 1};
    logic [15:0] m_rd  [2];
    logic        m_err [2];
    logic [15:0] mm    [2][0:32767];

    always #5 clk = ~clk;

    lc3b_mem_responder #(.ADDR_W(16), .LATENCY(4)) dut4 (
        .clk(clk), .reset(reset), .MEMEN(MEMEN), .R_W(R_W), .DATASIZE(DATASIZE),
        .ADDR(ADDR), .WDATA(WDATA), .RDATA(rdata4), .R(r4)
`ifdef MEM_ALIGN_CHECK_EN
        , .ERR(err4)
`endif
    );

    lc3b_mem_responder #(.ADDR_W(16), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .MEMEN(MEMEN), .R_W(R_W), .DATASIZE(DATASIZE),
        .ADDR(ADDR), .WDATA(WDATA), .RDATA(rdata1), .R(r1)
`ifdef MEM_ALIGN_CHECK_EN
        , .ERR(err1)
`endif
    );

`ifndef MEM_ALIGN_CHECK_EN
    assign err4 = 1'b0;
    assign err1 = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: R follows the count of consecutive MEMEN-high edges; the access
    // happens on the edge where that count first reaches the latency.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                run[k]   = 0;
                m_rd[k]  = 16'h0000;
                m_err[k] = 1'b0;
            end else if (!MEMEN) begin
                run[k] = 0;
            end else if (run[k] < lat[k]) begin
                run[k]++;
                if (run[k] == lat[k]) begin
                    logic        mis;
                    logic [14:0] wi;
                    logic [7:0]  b;
                    mis      = ALIGN && DATASIZE && ADDR[0];
                    m_err[k] = mis;
                    wi       = ADDR[15:1];
                    if (!mis) begin
                        if (R_W) begin
                            if (DATASIZE)     mm[k][wi]       = WDATA;
                            else if (ADDR[0]) mm[k][wi][15:8] = WDATA[7:0];
                            else              mm[k][wi][7:0]  = WDATA[7:0];
                        end else begin
                            b = ADDR[0] ? mm[k][wi][15:8] : mm[k][wi][7:0];
                            m_rd[k] = DATASIZE ? mm[k][wi] : {{8{b[7]}}, b};
                        end
                    end
                end
            end
        end
        if (!reset) chk_on = 1'b1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            if (chk_on) begin
                chk("r_lat4", 32'(r4), 32'(run[0] >= 4));
                chk("rdata_lat4", 32'(rdata4), 32'(m_rd[0]));
                chk("r_lat1", 32'(r1), 32'(run[1] >= 1));
                chk("rdata_lat1", 32'(rdata1), 32'(m_rd[1]));
                if (ALIGN) begin
                    chk("err_lat4", 32'(err4), 32'(r4 && m_err[0]));
                    chk("err_lat1", 32'(err1), 32'(r1 && m_err[1]));
                end
            end
        end
    end

    task automatic acc(input logic rw, input logic sz, input logic [15:0] a,
                       input logic [15:0] wd, input int hold,
                       output int e4, output int e1, output logic err_r);
        @(negedge clk);
        R_W = rw; DATASIZE = sz; ADDR = a; WDATA = wd; MEMEN = 1'b1;
        e4 = 0; e1 = 0; err_r = 1'b0;
        forever begin
            @(posedge clk); #1;
            e4++;
            if (r1 && e1 == 0) e1 = e4;
            if (r4) begin
                err_r = err4;
                break;
            end
            if (e4 >= 40) begin
                chk("r_timeout", 32'(r4), 32'd1);
                break;
            end
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            WDATA = ~WDATA;
        end
        if (hold > 0) chk("r_hold", 32'(r4), 32'd1);
        @(negedge clk);
        MEMEN = 1'b0;
        @(posedge clk); #1;
        chk("r_drop", 32'(r4), 32'd0);
    endtask

    int   e4, e1;
    logic er;

    initial begin
        reset = 1'b0; MEMEN = 1'b0; R_W = 1'b0; DATASIZE = 1'b1;
        ADDR = 16'h0; WDATA = 16'h0;
        repeat (2) @(negedge clk);
        chk("reset_r", 32'(r4), 32'd0);
        chk("reset_rdata", 32'(rdata4), 32'h0000);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_r", 32'(r4), 32'd0);

        acc(1'b1, 1'b1, 16'h0010, 16'hBEEF, 0, e4, e1, er);
        chk("lat4_edges", 32'(e4), 32'd4);
        chk("lat1_edges", 32'(e1), 32'd1);
        acc(1'b0, 1'b1, 16'h0010, 16'h0000, 0, e4, e1, er);
        chk("rd_beef", 32'(rdata4), 32'hBEEF);

        acc(1'b1, 1'b0, 16'h0011, 16'h0080, 0, e4, e1, er);
        acc(1'b0, 1'b1, 16'h0010, 16'h0000, 0, e4, e1, er);
        chk("rd_80ef", 32'(rdata4), 32'h80EF);
        acc(1'b0, 1'b0, 16'h0011, 16'h0000, 0, e4, e1, er);
        chk("rd_ff80", 32'(rdata4), 32'hFF80);
        acc(1'b0, 1'b0, 16'h0010, 16'h0000, 0, e4, e1, er);
        chk("rd_ffef", 32'(rdata4), 32'hFFEF);

        acc(1'b1, 1'b1, 16'h0020, 16'h5555, 0, e4, e1, er);
        @(negedge clk);
        R_W = 1'b1; DATASIZE = 1'b1; ADDR = 16'h0020; WDATA = 16'h1234; MEMEN = 1'b1;
        repeat (2) @(negedge clk);
        MEMEN = 1'b0;
        chk("abort_r", 32'(r4), 32'd0);
        @(negedge clk);
        acc(1'b0, 1'b1, 16'h0020, 16'h0000, 0, e4, e1, er);
        chk("abort_rd4", 32'(rdata4), 32'h5555);
        chk("abort_rd1", 32'(rdata1), 32'h1234);

        @(negedge clk);
        R_W = 1'b1; DATASIZE = 1'b1; ADDR = 16'h0020; WDATA = 16'h1234; MEMEN = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_wait_r", 32'(r4), 32'd0);
        chk("rst_wait_rdata", 32'(rdata4), 32'h0000);
        reset = 1'b1; MEMEN = 1'b0;
        @(negedge clk);
        acc(1'b0, 1'b1, 16'h0020, 16'h0000, 0, e4, e1, er);
        chk("rst_abort_rd4", 32'(rdata4), 32'h5555);

        acc(1'b1, 1'b1, 16'h0040, 16'h0F0F, 6, e4, e1, er);
        acc(1'b0, 1'b1, 16'h0040, 16'h0000, 0, e4, e1, er);
        chk("hold_rd4", 32'(rdata4), 32'h0F0F);
        chk("hold_rd1", 32'(rdata1), 32'h0F0F);
        chk("lat1_b2b", 32'(e1), 32'd1);

        if (ALIGN) begin
            acc(1'b1, 1'b1, 16'h0030, 16'hA5A5, 0, e4, e1, er);
            chk("err_aligned_wr", 32'(er), 32'd0);
            acc(1'b1, 1'b1, 16'h0031, 16'hFFFF, 0, e4, e1, er);
            chk("err_misaligned_wr", 32'(er), 32'd1);
            acc(1'b0, 1'b1, 16'h0030, 16'h0000, 0, e4, e1, er);
            chk("err_aligned_rd", 32'(er), 32'd0);
            chk("err_rd_unchanged", 32'(rdata4), 32'hA5A5);
            acc(1'b0, 1'b1, 16'h0031, 16'h0000, 0, e4, e1, er);
            chk("err_misaligned_rd", 32'(er), 32'd1);
            chk("err_rd_held", 32'(rdata4), 32'hA5A5);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
